alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue.sv | 225 ++++++++++++++++++++++
 tb/tb_alu_issue.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// ---------------------------------------------------------------------------
// alu_issue
// Decodes a MIPS-style instruction into ALU operands and an ALU operation
// code, then buffers the result in a 2-entry FIFO (output register plus skid
// register) with a valid/ready handshake on both sides.
//
// Ports
//   i_clk         rising-edge clock
//   i_reset       synchronous, active-low reset
//   i_valid       upstream decoded instruction present
//   o_ready       block can accept an instruction this cycle (registered)
//   i_opcode      instruction bits [31:26]
//   i_funct       instruction bits [5:0]
//   i_shamt       instruction bits [10:6]
//   i_imm         instruction bits [15:0]
//   i_rs_data     register rs value
//   i_rt_data     register rt value
//   i_flush       discard all held and incoming instructions
//   i_ready       ALU stage accepts the presented operation
//   o_valid       presented operation is valid
//   o_datoa       ALU operand A
//   o_datob       ALU operand B
//   o_shamt       ALU shift amount
//   o_alucontrol  ALU operation code
//   o_illegal     presented instruction has no ALU mapping
// ---------------------------------------------------------------------------
module alu_issue #(
    parameter int SIZEDATA = 32,
    parameter int SIZEOP   = 6,
    parameter int SIZESA   = 5
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [SIZEOP-1:0]   i_opcode,
    input  logic [SIZEOP-1:0]   i_funct,
    input  logic [SIZESA-1:0]   i_shamt,
    input  logic [15:0]         i_imm,
    input  logic [SIZEDATA-1:0] i_rs_data,
    input  logic [SIZEDATA-1:0] i_rt_data,
    input  logic                i_flush,
    input  logic                i_ready,
    output logic                o_valid,
    output logic [SIZEDATA-1:0] o_datoa,
    output logic [SIZEDATA-1:0] o_datob,
    output logic [SIZESA-1:0]   o_shamt,
    output logic [3:0]          o_alucontrol,
    output logic                o_illegal
);

    localparam logic [3:0] ALU_SLL     = 4'd0;
    localparam logic [3:0] ALU_SRL     = 4'd1;
    localparam logic [3:0] ALU_SRA     = 4'd2;
    localparam logic [3:0] ALU_SLLV    = 4'd3;
    localparam logic [3:0] ALU_SRLV    = 4'd4;
    localparam logic [3:0] ALU_SRAV    = 4'd5;
    localparam logic [3:0] ALU_ADDU    = 4'd6;
    localparam logic [3:0] ALU_SUBU    = 4'd7;
    localparam logic [3:0] ALU_OR      = 4'd8;
    localparam logic [3:0] ALU_XOR     = 4'd9;
    localparam logic [3:0] ALU_AND     = 4'd10;
    localparam logic [3:0] ALU_NOR     = 4'd11;
    localparam logic [3:0] ALU_SLT     = 4'd12;
    localparam logic [3:0] ALU_LUI     = 4'd13;
    localparam logic [3:0] ALU_ILLEGAL = 4'd15;

    // Entry layout: {operand A, operand B, shift amount, code, illegal}
    localparam int ENTRY_W = 2*SIZEDATA + SIZESA + 5;

    function automatic logic [3:0] decode_funct(input logic [SIZEOP-1:0] funct);
        case (funct)
            6'b000000: decode_funct = ALU_SLL;
            6'b000010: decode_funct = ALU_SRL;
            6'b000011: decode_funct = ALU_SRA;
            6'b000100: decode_funct = ALU_SLLV;
            6'b000110: decode_funct = ALU_SRLV;
            6'b000111: decode_funct = ALU_SRAV;
            6'b100001: decode_funct = ALU_ADDU;
            6'b100011: decode_funct = ALU_SUBU;
            6'b100100: decode_funct = ALU_AND;
            6'b100101: decode_funct = ALU_OR;
            6'b100110: decode_funct = ALU_XOR;
            6'b100111: decode_funct = ALU_NOR;
            6'b101010: decode_funct = ALU_SLT;
            default:   decode_funct = ALU_ILLEGAL;
        endcase
    endfunction

    function automatic logic [3:0] decode_opcode(input logic [SIZEOP-1:0] opcode);
        casez (opcode)
            6'b001000, 6'b001001: decode_opcode = ALU_ADDU;
            6'b001010:            decode_opcode = ALU_SLT;
            6'b001100:            decode_opcode = ALU_AND;
            6'b001101:            decode_opcode = ALU_OR;
            6'b001110:            decode_opcode = ALU_XOR;
            6'b001111:            decode_opcode = ALU_LUI;
            6'b100???, 6'b101???: decode_opcode = ALU_ADDU;  // load/store address
            6'b000100, 6'b000101: decode_opcode = ALU_SUBU;  // branch compare
            default:              decode_opcode = ALU_ILLEGAL;
        endcase
    endfunction

    function automatic logic [SIZEDATA-1:0] sign_ext(input logic [15:0] imm);
        sign_ext = {{(SIZEDATA-16){imm[15]}}, imm};
    endfunction

    function automatic logic [SIZEDATA-1:0] zero_ext(input logic [15:0] imm);
        zero_ext = {{(SIZEDATA-16){1'b0}}, imm};
    endfunction

    logic                is_rtype;
    logic                is_branch;
    logic                is_logic_imm;
    logic [3:0]          dec_code;
    logic                dec_illegal;
    logic [SIZEDATA-1:0] dec_a;
    logic [SIZEDATA-1:0] dec_b;
    logic [SIZESA-1:0]   dec_shamt;
    logic [ENTRY_W-1:0]  dec_entry;

    // Decode stage: combinational, captured into the FIFO on transfer in
    always_comb begin
        is_rtype     = (i_opcode == 6'b000000);
        is_branch    = (i_opcode == 6'b000100) || (i_opcode == 6'b000101);
        // Logical immediates are zero-extended; every other I-type sign-extends
        is_logic_imm = (i_opcode == 6'b001100) || (i_opcode == 6'b001101) ||
                       (i_opcode == 6'b001110);
        dec_code     = is_rtype ? decode_funct(i_funct) : decode_opcode(i_opcode);
        dec_illegal  = (dec_code == ALU_ILLEGAL);
        dec_a        = '0;
        dec_b        = '0;
        dec_shamt    = '0;
        if (!dec_illegal) begin
            dec_a = i_rs_data;
            if (is_rtype) begin
                dec_b     = i_rt_data;
                dec_shamt = i_shamt;
            end else if (is_branch) begin
                dec_b = i_rt_data;
            end else if (is_logic_imm) begin
                dec_b = zero_ext(i_imm);
            end else begin
                dec_b = sign_ext(i_imm);
            end
        end
        dec_entry = {dec_a, dec_b, dec_shamt, dec_code, dec_illegal};
    end

    logic [1:0]         count;
    logic [1:0]         count_next;
    logic               ready_q;
    logic [ENTRY_W-1:0] out_entry;
    logic [ENTRY_W-1:0] skid_entry;
    logic               in_xfer;
    logic               out_xfer;
    logic               load_out_new;
    logic               load_out_skid;
    logic               load_skid;

    assign in_xfer  = i_valid && ready_q;
    assign out_xfer = o_valid && i_ready;

    // FIFO control: which register takes which entry, and the next occupancy
    always_comb begin
        count_next    = count;
        load_out_new  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (count)
            2'd0: begin
                if (in_xfer) begin
                    load_out_new = 1'b1;
                    count_next   = 2'd1;
                end
            end
            2'd1: begin
                if (in_xfer && out_xfer) begin
                    load_out_new = 1'b1;
                end else if (in_xfer) begin
                    load_skid  = 1'b1;
                    count_next = 2'd2;
                end else if (out_xfer) begin
                    count_next = 2'd0;
                end
            end
            default: begin
                // ready_q is low when full, so only the skid promotion can occur
                if (out_xfer) begin
                    load_out_skid = 1'b1;
                    count_next    = 2'd1;
                end
            end
        endcase
    end

    // Storage stage: output register and skid register
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            count      <= 2'd0;
            ready_q    <= 1'b0;
            out_entry  <= '0;
            skid_entry <= '0;
        end else if (i_flush) begin
            count   <= 2'd0;
            ready_q <= 1'b1;
        end else begin
            count   <= count_next;
            ready_q <= (count_next != 2'd2);
            if (load_out_new) begin
                out_entry <= dec_entry;
            end else if (load_out_skid) begin
                out_entry <= skid_entry;
            end
            if (load_skid) begin
                skid_entry <= dec_entry;
            end
        end
    end

    assign o_ready = ready_q;
    assign o_valid = (count != 2'd0);
    assign {o_datoa, o_datob, o_shamt, o_alucontrol, o_illegal} = out_entry;

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        flush;
    logic        alu_ready;
    logic        out_valid;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic [4:0]  out_shamt;
    logic [3:0]  alucontrol;
    logic        illegal;

    int checks = 0;
    int passed = 0;

    alu_issue dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_valid      (in_valid),
        .o_ready      (out_ready),
        .i_opcode     (opcode),
        .i_funct      (funct),
        .i_shamt      (shamt),
        .i_imm        (imm),
        .i_rs_data    (rs_data),
        .i_rt_data    (rt_data),
        .i_flush      (flush),
        .i_ready      (alu_ready),
        .o_valid      (out_valid),
        .o_datoa      (data_a),
        .o_datob      (data_b),
        .o_shamt      (out_shamt),
        .o_alucontrol (alucontrol),
        .o_illegal    (illegal)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inst(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sa,
                            input logic [15:0] im, input logic [31:0] rs, input logic [31:0] rt);
        in_valid = 1'b1;
        opcode   = op;
        funct    = fn;
        shamt    = sa;
        imm      = im;
        rs_data  = rs;
        rt_data  = rt;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        flush     = 1'b0;
        alu_ready = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", out_valid); else passed++;
        checks++; if (out_ready !== 1'b0) $display("FAIL reset_ready got %0b want 0", out_ready); else passed++;
        checks++; if ({data_a, data_b} !== 64'h0) $display("FAIL reset_data got %h want 0", {data_a, data_b}); else passed++;
        checks++; if ({out_shamt, alucontrol, illegal} !== 10'h0) $display("FAIL reset_ctl got %h want 0", {out_shamt, alucontrol, illegal}); else passed++;
        rst_n = 1'b1;
        tick();
        checks++; if (out_ready !== 1'b1) $display("FAIL reset_release_ready got %0b want 1", out_ready); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_release_valid got %0b want 0", out_valid); else passed++;
    endtask

    task automatic test_addu();
        alu_ready = 1'b1;
        set_inst(6'b000000, 6'b100001, 5'd3, 16'h0000, 32'd5, 32'd7);
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) $display("FAIL addu_valid got %0b want 1", out_valid); else passed++;
        checks++; if (alucontrol !== 4'd6) $display("FAIL addu_code got %0d want 6", alucontrol); else passed++;
        checks++; if (data_a !== 32'd5) $display("FAIL addu_a got %h want 5", data_a); else passed++;
        checks++; if (data_b !== 32'd7) $display("FAIL addu_b got %h want 7", data_b); else passed++;
        checks++; if (out_shamt !== 5'd3) $display("FAIL addu_shamt got %0d want 3", out_shamt); else passed++;
        tick();
        checks++; if (out_valid !== 1'b0) $display("FAIL addu_consumed got %0b want 0", out_valid); else passed++;
    endtask

    // Streams R-type functs back to back with i_ready=1: each cycle one in, one out
    task automatic test_rtype_stream();
        logic [5:0] fn [13] = '{6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111,
                                6'b100011, 6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b101010,
                                6'b000001};
        logic [3:0] code [13] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd10, 4'd8, 4'd9,
                                  4'd11, 4'd12, 4'd15};
        alu_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            set_inst(6'b000000, fn[i], 5'd1, 16'h0, 32'(i + 100), 32'h55);
            tick();
            checks++;
            if (alucontrol !== code[i] || out_valid !== 1'b1 || illegal !== (code[i] == 4'd15) ||
                data_a !== ((code[i] == 4'd15) ? 32'h0 : 32'(i + 100)))
                $display("FAIL rtype_%0d got code=%0d v=%0b ill=%0b a=%h want code=%0d", i,
                         alucontrol, out_valid, illegal, data_a, code[i]);
            else passed++;
        end
        checks++; if (out_ready !== 1'b1) $display("FAIL stream_ready got %0b want 1", out_ready); else passed++;
        drain();
    endtask

    task automatic test_imm_ext();
        alu_ready = 1'b1;
        set_inst(6'b001101, 6'b0, 5'd5, 16'h8000, 32'd1, 32'hDEAD);
        tick();
        checks++; if ({alucontrol, data_a, data_b, out_shamt} !== {4'd8, 32'd1, 32'h0000_8000, 5'd0})
            $display("FAIL ori got code=%0d a=%h b=%h sa=%0d want 8 1 00008000 0", alucontrol, data_a, data_b, out_shamt); else passed++;
        set_inst(6'b001000, 6'b0, 5'd0, 16'h8000, 32'd1, 32'hDEAD);
        tick();
        checks++; if ({alucontrol, data_b} !== {4'd6, 32'hFFFF_8000})
            $display("FAIL addi got code=%0d b=%h want 6 ffff8000", alucontrol, data_b); else passed++;
        set_inst(6'b001100, 6'b0, 5'd0, 16'hF0F0, 32'd2, 32'hDEAD);
        tick();
        checks++; if ({alucontrol, data_b} !== {4'd10, 32'h0000_F0F0})
            $display("FAIL andi got code=%0d b=%h want 10 0000f0f0", alucontrol, data_b); else passed++;
        set_inst(6'b100011, 6'b0, 5'd0, 16'hFFFC, 32'd2, 32'hDEAD);
        tick();
        checks++; if ({alucontrol, data_b} !== {4'd6, 32'hFFFF_FFFC})
            $display("FAIL lw got code=%0d b=%h want 6 fffffffc", alucontrol, data_b); else passed++;
        set_inst(6'b000100, 6'b0, 5'd0, 16'h0010, 32'd3, 32'd9);
        tick();
        checks++; if ({alucontrol, data_a, data_b} !== {4'd7, 32'd3, 32'd9})
            $display("FAIL beq got code=%0d a=%h b=%h want 7 3 9", alucontrol, data_a, data_b); else passed++;
        drain();
    endtask

    task automatic test_illegal();
        alu_ready = 1'b1;
        set_inst(6'b111111, 6'b100001, 5'd4, 16'h1234, 32'd8, 32'd9);
        tick();
        checks++; if ({out_valid, alucontrol, illegal, data_a, data_b} !== {1'b1, 4'd15, 1'b1, 64'h0})
            $display("FAIL illegal got v=%0b code=%0d ill=%0b a=%h b=%h want 1 15 1 0 0", out_valid, alucontrol, illegal, data_a, data_b); else passed++;
        set_inst(6'b001111, 6'b0, 5'd0, 16'h1234, 32'd0, 32'd0);
        tick();
        checks++; if ({alucontrol, illegal, data_b} !== {4'd13, 1'b0, 32'h0000_1234})
            $display("FAIL lui got code=%0d ill=%0b b=%h want 13 0 00001234", alucontrol, illegal, data_b); else passed++;
        drain();
    endtask

    task automatic test_back_to_back();
        alu_ready = 1'b0;
        set_inst(6'b000000, 6'b100001, 5'd0, 16'h0, 32'd1, 32'd0);
        tick();
        checks++; if ({out_valid, out_ready, data_a} !== {2'b11, 32'd1})
            $display("FAIL b2b_first got v=%0b r=%0b a=%h want 1 1 1", out_valid, out_ready, data_a); else passed++;
        rs_data = 32'd2;
        tick();
        checks++; if ({out_valid, out_ready, data_a} !== {2'b10, 32'd1})
            $display("FAIL b2b_full got v=%0b r=%0b a=%h want 1 0 1", out_valid, out_ready, data_a); else passed++;
        rs_data = 32'd3;
        tick();
        checks++; if ({out_valid, out_ready, data_a} !== {2'b10, 32'd1})
            $display("FAIL b2b_stall got v=%0b r=%0b a=%h want 1 0 1", out_valid, out_ready, data_a); else passed++;
        in_valid  = 1'b0;
        alu_ready = 1'b1;
        tick();
        checks++; if ({out_valid, out_ready, data_a} !== {2'b11, 32'd2})
            $display("FAIL b2b_second got v=%0b r=%0b a=%h want 1 1 2", out_valid, out_ready, data_a); else passed++;
        tick();
        checks++; if (out_valid !== 1'b0) $display("FAIL b2b_empty got %0b want 0", out_valid); else passed++;
    endtask

    task automatic test_flush();
        alu_ready = 1'b0;
        set_inst(6'b000000, 6'b100001, 5'd0, 16'h0, 32'd10, 32'd0);
        tick();
        rs_data = 32'd11;
        tick();
        checks++; if (out_ready !== 1'b0) $display("FAIL flush_prefull got %0b want 0", out_ready); else passed++;
        flush   = 1'b1;
        rs_data = 32'd12;
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        checks++; if ({out_valid, out_ready} !== 2'b01)
            $display("FAIL flush_state got v=%0b r=%0b want 0 1", out_valid, out_ready); else passed++;
        alu_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) $display("FAIL flush_nothing got %0b want 0", out_valid); else passed++;
    endtask

    task automatic test_reset_midstream();
        alu_ready = 1'b0;
        set_inst(6'b000000, 6'b100001, 5'd0, 16'h0, 32'd20, 32'd0);
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) $display("FAIL mid_held got %0b want 1", out_valid); else passed++;
        rst_n = 1'b0;
        tick();
        checks++; if ({out_valid, out_ready, data_a} !== {2'b00, 32'd0})
            $display("FAIL mid_reset got v=%0b r=%0b a=%h want 0 0 0", out_valid, out_ready, data_a); else passed++;
        rst_n = 1'b1;
        tick();
        checks++; if ({out_valid, out_ready} !== 2'b01)
            $display("FAIL mid_release got v=%0b r=%0b want 0 1", out_valid, out_ready); else passed++;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        opcode    = '0;
        funct     = '0;
        shamt     = '0;
        imm       = '0;
        rs_data   = '0;
        rt_data   = '0;
        flush     = 1'b0;
        alu_ready = 1'b0;
        test_reset();
        test_addu();
        test_rtype_stream();
        test_imm_ext();
        test_illegal();
        test_back_to_back();
        test_flush();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
